wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/mips_pkg.sv | 20 ++
 rtl/wb_stage_load_align.sv | 50 +++++
 rtl/wb_stage.sv | 96 +++++++++
 tb/tb_wb_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the pipeline back end.
// Contents: load-size and result-source encodings, plus the architectural
// word width that the load aligner is built around.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    LD_BYTE = 2'b00,
    LD_HALF = 2'b01,
    LD_WORD = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

  typedef enum logic {
    SEL_ALU = 1'b0,
    SEL_MEM = 1'b1
  } src_sel_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load-field extraction and misalignment check.
// Ports:
//   mem_data   - raw aligned memory word (big-endian byte order)
//   ld_size    - LD_BYTE / LD_HALF / LD_WORD / LD_RSVD
//   ld_signed  - sign-extend (1) or zero-extend (0) sub-word loads
//   addr_lo    - low two bits of the load address
//   data       - extracted, extended load value
//   misaligned - access cannot be performed at this address/size
module load_align
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] mem_data,
  input  logic [1:0]        ld_size,
  input  logic              ld_signed,
  input  logic [1:0]        addr_lo,
  output logic [WORD_W-1:0] data,
  output logic              misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Big-endian: address 0 is the most significant byte.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'd0:    byte_sel = mem_data[31:24];
      2'd1:    byte_sel = mem_data[23:16];
      2'd2:    byte_sel = mem_data[15:8];
      default: byte_sel = mem_data[7:0];
    endcase
  end

  assign half_sel = addr_lo[1] ? mem_data[15:0] : mem_data[31:16];

  always_comb begin
    data       = mem_data;
    misaligned = 1'b0;
    case (ld_size)
      LD_BYTE: data = {{24{ld_signed & byte_sel[7]}}, byte_sel};
      LD_HALF: begin
        data       = {{16{ld_signed & half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      LD_WORD: misaligned = (addr_lo != 2'd0);
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline register.
// Takes one transaction per cycle from MEM, selects ALU result or aligned
// load data, and registers the register-file write port, the forwarding
// bus, the misalignment pulse and the retire counter.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   in_valid / in_ready      - handshake from MEM (in_ready = !stall)
//   stall, in_flush          - hold request from decode, discard current txn
//   in_rd, in_rd_we, in_sel  - destination, write enable, result source
//   in_alu, in_mem_data      - ALU result, raw memory word
//   in_ld_size, in_ld_signed, in_addr_lo - load shape
//   we, reg_w, bus_w         - register-file write port
//   fwd_valid/fwd_reg/fwd_data - forwarding copy of the write port
//   misalign_err             - one-cycle pulse on a misaligned load
//   retire_cnt               - retired instruction count (wraps)
module wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              in_flush,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  input  logic [1:0]        in_addr_lo,
  output logic              we,
  output logic [REG_AW-1:0] reg_w,
  output logic [DATA_W-1:0] bus_w,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_err,
  output logic [31:0]       retire_cnt
);

  logic [DATA_W-1:0] ld_data;
  logic              ld_mis;
  logic              is_load;
  logic              mis;
  logic              live;
  logic [DATA_W-1:0] result;
  logic [31:0]       cnt_q;

  load_align u_load_align (
    .mem_data   (in_mem_data),
    .ld_size    (in_ld_size),
    .ld_signed  (in_ld_signed),
    .addr_lo    (in_addr_lo),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  assign in_ready = !stall;
  assign is_load  = (in_sel == SEL_MEM);
  assign mis      = is_load && ld_mis;
  assign result   = is_load ? ld_data : in_alu;

  // Flushed transactions are handshaken but otherwise invisible.
  assign live = in_valid && in_ready && !in_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we           <= 1'b0;
      reg_w        <= '0;
      bus_w        <= '0;
      misalign_err <= 1'b0;
      cnt_q        <= '0;
    end else begin
      we           <= 1'b0;
      misalign_err <= 1'b0;
      if (live) begin
        we           <= in_rd_we && (in_rd != '0) && !mis;
        reg_w        <= in_rd;
        bus_w        <= result;
        misalign_err <= mis;
        cnt_q        <= cnt_q + 32'd1;
      end
    end
  end

  assign fwd_valid  = we;
  assign fwd_reg    = reg_w;
  assign fwd_data   = bus_w;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, stall, in_flush;
  logic [4:0]  in_rd;
  logic        in_rd_we, in_sel;
  logic [31:0] in_alu, in_mem_data;
  logic [1:0]  in_ld_size;
  logic        in_ld_signed;
  logic [1:0]  in_addr_lo;
  logic        we;
  logic [4:0]  reg_w;
  logic [31:0] bus_w;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        misalign_err;
  logic [31:0] retire_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .stall        (stall),
    .in_flush     (in_flush),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .in_sel       (in_sel),
    .in_alu       (in_alu),
    .in_mem_data  (in_mem_data),
    .in_ld_size   (in_ld_size),
    .in_ld_signed (in_ld_signed),
    .in_addr_lo   (in_addr_lo),
    .we           (we),
    .reg_w        (reg_w),
    .bus_w        (bus_w),
    .fwd_valid    (fwd_valid),
    .fwd_reg      (fwd_reg),
    .fwd_data     (fwd_data),
    .misalign_err (misalign_err),
    .retire_cnt   (retire_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Full output-port check against expected write-port values.
  task automatic check_out(input string tag, input logic exp_we, input logic [4:0] exp_rd,
                           input logic [31:0] exp_bus, input logic exp_mis,
                           input logic [31:0] exp_cnt);
    check({tag, ".we"},        {31'd0, we},           {31'd0, exp_we});
    check({tag, ".reg_w"},     {27'd0, reg_w},        {27'd0, exp_rd});
    check({tag, ".bus_w"},     bus_w,                 exp_bus);
    check({tag, ".fwd_valid"}, {31'd0, fwd_valid},    {31'd0, exp_we});
    check({tag, ".fwd_reg"},   {27'd0, fwd_reg},      {27'd0, exp_rd});
    check({tag, ".fwd_data"},  fwd_data,              exp_bus);
    check({tag, ".mis"},       {31'd0, misalign_err}, {31'd0, exp_mis});
    check({tag, ".cnt"},       retire_cnt,            exp_cnt);
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; in_flush = 0; in_rd = 0; in_rd_we = 0; in_sel = 0;
    in_alu = 0; in_mem_data = 0; in_ld_size = 0; in_ld_signed = 0; in_addr_lo = 0;
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
    idle();
    in_valid = 1; in_rd_we = 1; in_sel = 0; in_rd = rd; in_alu = val;
  endtask

  task automatic ld_op(input logic [4:0] rd, input logic [31:0] mem, input logic [1:0] size,
                       input logic sgn, input logic [1:0] lo);
    idle();
    in_valid = 1; in_rd_we = 1; in_sel = 1; in_rd = rd; in_mem_data = mem;
    in_ld_size = size; in_ld_signed = sgn; in_addr_lo = lo;
    in_alu = 32'h5A5A_5A5A;
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    check_out("reset", 0, 0, 32'h0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;

    alu_op(5, 32'hDEAD_BEEF); step();
    check_out("alu", 1, 5, 32'hDEAD_BEEF, 0, 1);
    @(negedge clk); idle(); step();
    check_out("idle_hold", 0, 5, 32'hDEAD_BEEF, 0, 1);

    @(negedge clk); ld_op(7, 32'h1280_FF34, 2'b00, 1, 2'd1); step();
    check_out("lb_s1", 1, 7, 32'hFFFF_FF80, 0, 2);
    @(negedge clk); ld_op(7, 32'h1280_FF34, 2'b00, 0, 2'd1); step();
    check_out("lb_u1", 1, 7, 32'h0000_0080, 0, 3);
    @(negedge clk); ld_op(8, 32'h1280_FF34, 2'b00, 1, 2'd3); step();
    check_out("lb_s3", 1, 8, 32'h0000_0034, 0, 4);
    @(negedge clk); ld_op(8, 32'h1280_FF34, 2'b00, 0, 2'd2); step();
    check_out("lb_u2", 1, 8, 32'h0000_00FF, 0, 5);
    @(negedge clk); ld_op(9, 32'h0000_ABCD, 2'b01, 1, 2'd2); step();
    check_out("lh_s2", 1, 9, 32'hFFFF_ABCD, 0, 6);
    @(negedge clk); ld_op(9, 32'hABCD_1234, 2'b01, 0, 2'd0); step();
    check_out("lh_u0", 1, 9, 32'h0000_ABCD, 0, 7);

    @(negedge clk); ld_op(10, 32'h0000_ABCD, 2'b01, 1, 2'd3); step();
    check("lh_mis.mis", {31'd0, misalign_err}, 32'd1);
    check("lh_mis.we",  {31'd0, we},           32'd0);
    check("lh_mis.fv",  {31'd0, fwd_valid},    32'd0);
    check("lh_mis.cnt", retire_cnt,            32'd8);
    @(negedge clk); idle(); step();
    check("mis_pulse_end", {31'd0, misalign_err}, 32'd0);

    @(negedge clk); ld_op(11, 32'hCAFE_F00D, 2'b10, 0, 2'd0); step();
    check_out("lw_0", 1, 11, 32'hCAFE_F00D, 0, 9);
    @(negedge clk); ld_op(12, 32'hCAFE_F00D, 2'b10, 0, 2'd2); step();
    check("lw_mis.mis", {31'd0, misalign_err}, 32'd1);
    check("lw_mis.we",  {31'd0, we},           32'd0);
    check("lw_mis.cnt", retire_cnt,            32'd10);
    @(negedge clk); ld_op(13, 32'hCAFE_F00D, 2'b11, 0, 2'd0); step();
    check("rsvd.mis", {31'd0, misalign_err}, 32'd1);
    check("rsvd.we",  {31'd0, we},           32'd0);
    check("rsvd.cnt", retire_cnt,            32'd11);

    // ALU op ignores load fields even if they would be misaligned
    @(negedge clk); alu_op(14, 32'h0BAD_F00D); in_ld_size = 2'b11; in_addr_lo = 2'd3; step();
    check_out("alu_ign_ld", 1, 14, 32'h0BAD_F00D, 0, 12);

    @(negedge clk); alu_op(0, 32'h0000_1234); step();
    check_out("r0", 0, 0, 32'h0000_1234, 0, 13);

    @(negedge clk); alu_op(9, 32'h5555_5555); in_flush = 1; step();
    check_out("flush", 0, 0, 32'h0000_1234, 0, 13);
    @(negedge clk); ld_op(9, 32'h0, 2'b10, 0, 2'd1); in_flush = 1; step();
    check_out("flush_mis", 0, 0, 32'h0000_1234, 0, 13);

    @(negedge clk); alu_op(3, 32'h7777_7777); stall = 1;
    #1 check("stall.ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out($sformatf("stall%0d", i), 0, 0, 32'h0000_1234, 0, 13);
    end
    @(negedge clk); in_flush = 1; step();
    check_out("stall_flush", 0, 0, 32'h0000_1234, 0, 13);
    @(negedge clk); stall = 0; in_flush = 0;
    #1 check("unstall.ready", {31'd0, in_ready}, 32'd1);
    step();
    check_out("after_stall", 1, 3, 32'h7777_7777, 0, 14);

    // Reset in the middle of a cycle with a transaction pending
    @(negedge clk); alu_op(6, 32'h1111_2222);
    #2 rst = 1;
    #1 check_out("rst_async", 0, 0, 32'h0, 0, 0);
    step();
    @(negedge clk); rst = 0;
    #1 check_out("rst_lost", 0, 0, 32'h0, 0, 0);
    step();
    check_out("post_rst", 1, 6, 32'h1111_2222, 0, 1);

    // Counter wrap: preset the count register, then retire one more
    @(negedge clk); dut.cnt_q = 32'hFFFF_FFFF; alu_op(2, 32'h0000_0042); step();
    check_out("wrap", 1, 2, 32'h0000_0042, 0, 0);

    @(negedge clk); idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
